pipeline_mem_arbiter: RTL and testbench

//   Shares one single-port unified memory between the IF-stage instruction fetch
//   and the MEM-stage data access of the 5-stage pipeline.

---
 rtl/pipeline_mem_arbiter_pkg.sv | 17 +
 rtl/pipeline_mem_arbiter_timer.sv | 24 ++
 rtl/pipeline_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter and its latency timer.
package arb_defs;
  localparam int LATENCY_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;
endpackage

// File: rtl/pipeline_mem_arbiter_timer.sv
// Memory latency down-counter: loads LATENCY-1 on start, done while the count is zero.
module mem_latency_timer
  import arb_defs::*;
#(
  parameter int LATENCY = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_done
);
  logic [LATENCY_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_cnt <= '0;
    else if (i_start)
      r_cnt <= LATENCY_W'(LATENCY - 1);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - LATENCY_W'(1);
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, data-first
// with a bounded deferral count that forces fetch through.
//   state | meaning
//   IDLE  | no access in flight, arbitrate every cycle
//   ISSUE | one-cycle strobe of the grantee's access
//   WAIT  | memory latency, capture read data on the last cycle
//   RESP  | ack the grantee, re-arbitrate with the grantee masked
module pipeline_mem_arbiter
  import arb_defs::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int LATENCY   = 2,
  parameter int MAX_DEFER = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_stall,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_stall,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int DEFER_W = $clog2(MAX_DEFER + 1);

  state_t              r_state, w_next_state;
  grant_t              r_grant, w_win;
  logic [DEFER_W-1:0]  r_defer;
  logic                r_store;
  logic                w_arb, w_i_cand, w_d_cand, w_done;
  logic                w_iss_re, w_iss_we, w_cap_i, w_cap_d;
  logic                r_if_ack, r_d_ack, r_mem_re, r_mem_we;
  logic [31:0]         r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata, r_mem_wdata;
  logic [ADDR_W-1:0]   r_mem_addr;

  mem_latency_timer #(.LATENCY(LATENCY)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (r_state == ISSUE),
    .o_done  (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // The grantee still holds its request during RESP, so it is masked there.
  always_comb begin
    w_arb    = (r_state == IDLE) || (r_state == RESP);
    w_i_cand = i_if_req && !((r_state == RESP) && (r_grant == GNT_I));
    w_d_cand = i_d_req  && !((r_state == RESP) && (r_grant == GNT_D));
    w_win    = GNT_NONE;
    if (w_arb) begin
      if (w_i_cand && (!w_d_cand || r_defer == DEFER_W'(MAX_DEFER)))
        w_win = GNT_I;
      else if (w_d_cand)
        w_win = GNT_D;
    end
    w_next_state = r_state;
    case (r_state)
      IDLE, RESP: w_next_state = (w_win != GNT_NONE) ? ISSUE : IDLE;
      ISSUE:      w_next_state = WAIT;
      WAIT:       w_next_state = w_done ? RESP : WAIT;
      default:    w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_iss_re = (w_win == GNT_I) || ((w_win == GNT_D) && !i_d_we);
    w_iss_we = (w_win == GNT_D) && i_d_we;
    w_cap_i  = (r_state == WAIT) && w_done && (r_grant == GNT_I);
    w_cap_d  = (r_state == WAIT) && w_done && (r_grant == GNT_D);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_grant     <= GNT_NONE;
      r_defer     <= '0;
      r_store     <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_arb) begin
        r_grant <= w_win;
        if (w_win == GNT_I)
          r_defer <= '0;
        else if (w_i_cand && r_defer != DEFER_W'(MAX_DEFER))
          r_defer <= r_defer + DEFER_W'(1);
      end
      r_mem_re <= w_iss_re;
      r_mem_we <= w_iss_we;
      if (w_win == GNT_I) begin
        r_mem_addr <= i_if_addr;
      end else if (w_win == GNT_D) begin
        r_mem_addr  <= i_d_addr;
        r_mem_wdata <= i_d_wdata;
        r_store     <= i_d_we;
      end
      r_if_ack <= w_cap_i;
      r_d_ack  <= w_cap_d;
      if (w_cap_i) r_if_rdata <= i_mem_rdata[31:0];
      if (w_cap_d && !r_store) r_d_rdata <= i_mem_rdata;
    end
  end

  assign o_if_ack    = r_if_ack;
  assign o_d_ack     = r_d_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_stall  = i_if_req & ~r_if_ack;
  assign o_d_stall   = i_d_req & ~r_d_ack;
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Scoreboard bench: transaction-level arbitration model predicts strobes and acks,
// a memory device model answers the DUT, a monitor compares.
module tb_pipeline_mem_arbiter;
  localparam int LAT  = 2;
  localparam int MAXD = 3;
  localparam int RCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic if_ack, if_stall, d_ack, d_stall, mem_re, mem_we;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;

  logic l1_d_req;
  logic [63:0] l1_d_addr, l1_mem_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic l1_if_ack, l1_if_stall, l1_d_ack, l1_d_stall, l1_mem_re, l1_mem_we;
  logic [31:0] l1_if_rdata;

  pipeline_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(LAT), .MAX_DEFER(MAXD)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .o_if_stall(if_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata), .o_d_stall(d_stall),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata));

  pipeline_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(1), .MAX_DEFER(MAXD)) dut_l1 (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(1'b0), .i_if_addr(64'h0), .o_if_ack(l1_if_ack), .o_if_rdata(l1_if_rdata),
    .o_if_stall(l1_if_stall),
    .i_d_req(l1_d_req), .i_d_we(1'b0), .i_d_addr(l1_d_addr), .i_d_wdata(64'h0),
    .o_d_ack(l1_d_ack), .o_d_rdata(l1_d_rdata), .o_d_stall(l1_d_stall),
    .o_mem_re(l1_mem_re), .o_mem_we(l1_mem_we), .o_mem_addr(l1_mem_addr),
    .o_mem_wdata(l1_mem_wdata), .i_mem_rdata(l1_mem_rdata));

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int who; int ack_cyc; logic [63:0] data; } resp_t;
  typedef struct { int issue_cyc; logic re; logic we; logic [63:0] addr; logic [63:0] wdata; } iss_t;
  typedef struct { int c; logic [63:0] d; } rd_t;
  resp_t rq[$];
  iss_t  iq[$];
  rd_t   pend[$];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] dev_mem [logic [63:0]];

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction
  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [63:0] dev_read(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // Reference: an arbitration happens in an idle cycle or in the ack cycle of the
  // previous access; each granted access acks LAT+2 cycles after it was arbitrated.
  int next_arb = 0, resp_who = 0, defer = 0;
  logic [63:0] last_load = '0;
  initial forever begin
    bit ic, dc;
    int win;
    logic [63:0] v;
    @(negedge clk);
    if (reset) begin
      rq.delete(); iq.delete();
      defer = 0; resp_who = 0; next_arb = cyc + 1; last_load = '0;
    end else if (cyc == next_arb) begin
      ic = if_req && (resp_who != 1);
      dc = d_req && (resp_who != 2);
      win = 0;
      if (ic && (!dc || defer == MAXD)) win = 1;
      else if (dc) win = 2;
      if (win == 1) defer = 0;
      else if (ic) defer = (defer < MAXD) ? defer + 1 : MAXD;
      if (win == 0) begin
        next_arb = cyc + 1; resp_who = 0;
      end else begin
        if (win == 1) begin
          v = ref_read(if_addr);
          iq.push_back('{cyc + 1, 1'b1, 1'b0, if_addr, 64'h0});
          rq.push_back('{1, cyc + LAT + 2, {32'h0, v[31:0]}});
        end else if (d_we) begin
          ref_mem[d_addr] = d_wdata;
          iq.push_back('{cyc + 1, 1'b0, 1'b1, d_addr, d_wdata});
          rq.push_back('{2, cyc + LAT + 2, last_load});
        end else begin
          last_load = ref_read(d_addr);
          iq.push_back('{cyc + 1, 1'b1, 1'b0, d_addr, 64'h0});
          rq.push_back('{2, cyc + LAT + 2, last_load});
        end
        next_arb = cyc + LAT + 2; resp_who = win;
      end
    end
  end

  // Memory device: reads answered exactly LAT cycles after the strobe, garbage otherwise.
  initial forever begin
    @(negedge clk);
    if (mem_we) dev_mem[mem_addr] = mem_wdata;
    if (mem_re) pend.push_back('{cyc + LAT, dev_read(mem_addr)});
  end
  initial forever begin
    @(posedge clk); #1;
    while (pend.size() > 0 && pend[0].c < cyc) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].c == cyc) mem_rdata = pend.pop_front().d;
    else mem_rdata = {$urandom, $urandom};
  end

  int l1_rd_cyc = -10;
  logic [63:0] l1_addr_seen = '0;
  initial forever begin
    @(negedge clk);
    if (l1_mem_re) begin l1_rd_cyc = cyc + 1; l1_addr_seen = l1_mem_addr; end
  end
  initial forever begin
    @(posedge clk); #1;
    l1_mem_rdata = (cyc == l1_rd_cyc) ? 64'h1234 : {$urandom, $urandom};
  end

  // Monitor
  initial forever begin
    iss_t e; resp_t r;
    bit exp_ai, exp_ad;
    @(negedge clk); #1;
    if (!reset) begin
      exp_ai = rq.size() > 0 && rq[0].ack_cyc == cyc && rq[0].who == 1;
      exp_ad = rq.size() > 0 && rq[0].ack_cyc == cyc && rq[0].who == 2;
      chk("if_stall", 64'(if_stall), 64'(if_req && !exp_ai));
      chk("d_stall", 64'(d_stall), 64'(d_req && !exp_ad));
      if (mem_re || mem_we) begin
        if (iq.size() == 0) chk("unexpected_strobe", 64'(mem_re | mem_we), 64'h0);
        else begin
          e = iq.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.issue_cyc));
          chk("mem_re", 64'(mem_re), 64'(e.re));
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end else if (iq.size() > 0 && iq[0].issue_cyc <= cyc) begin
        chk("missing_strobe", 64'h0, 64'h1);
        void'(iq.pop_front());
      end
      if (if_ack || d_ack) begin
        if (rq.size() == 0) chk("unexpected_ack", {62'h0, d_ack, if_ack}, 64'h0);
        else begin
          r = rq.pop_front();
          chk("ack_who", {62'h0, d_ack, if_ack}, 64'(r.who));
          chk("ack_cycle", 64'(cyc), 64'(r.ack_cyc));
          chk("ack_data", (r.who == 1) ? {32'h0, if_rdata} : d_rdata, r.data);
        end
      end else if (rq.size() > 0 && rq[0].ack_cyc <= cyc) begin
        chk("missing_ack", 64'h0, 64'h1);
        void'(rq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_d, output int c);
    c = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #2;
      if (is_d ? d_ack : if_ack) begin c = cyc; break; end
    end
    if (c < 0) chk(is_d ? "d_ack_timeout" : "if_ack_timeout", 64'h0, 64'h1);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = 64'($urandom_range(0, 7)) << 3;
    if ($urandom_range(0, 3) == 0) a[63] = 1'b1;
    return a;
  endfunction

  initial begin
    int t, c, cd, ci;
    bit seen, si, sd;
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    l1_d_req = 0; l1_d_addr = '0; l1_mem_rdata = '0;
    ref_mem[64'h10] = 64'hDEADBEEF; dev_mem[64'h10] = 64'hDEADBEEF;
    idle(3); reset = 0;
    @(negedge clk); #2;
    chk("rst_acks", {62'h0, d_ack, if_ack}, 64'h0);
    chk("rst_strobes", {62'h0, mem_we, mem_re}, 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);

    // LATENCY=1 single load
    idle(1); l1_d_addr = 64'h8; l1_d_req = 1; t = cyc; c = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #2;
      if (l1_d_ack) begin c = cyc; break; end
    end
    chk("l1_latency", 64'(c - t), 64'd3);
    chk("l1_rdata", l1_d_rdata, 64'h1234);
    chk("l1_addr", l1_addr_seen, 64'h8);
    idle(1); l1_d_req = 0;

    // Single fetch
    idle(2); if_addr = 64'h10; if_req = 1; t = cyc;
    wait_ack(0, c);
    chk("fetch_latency", 64'(c - t), 64'(LAT + 2));
    chk("fetch_rdata", {32'h0, if_rdata}, 64'hDEADBEEF);
    idle(1); if_req = 0;

    // Simultaneous store and fetch: data first, fetch served from data's RESP
    idle(2); d_addr = 64'h40; d_we = 1; d_wdata = 64'h5; d_req = 1; if_addr = 64'h18; if_req = 1;
    wait_ack(1, cd); idle(1); d_req = 0;
    wait_ack(0, ci);
    chk("fetch_after_data_gap", 64'(ci - cd), 64'(LAT + 2));
    idle(1); if_req = 0;

    // Load, store (rdata unchanged), load back
    idle(2); d_addr = 64'h20; d_we = 0; d_req = 1;
    wait_ack(1, c); chk("load1_rdata", d_rdata, init_val(64'h20));
    idle(1); d_req = 0;
    idle(1); d_addr = 64'h48; d_we = 1; d_wdata = 64'hCAFE_F00D_1234_5678; d_req = 1;
    wait_ack(1, c); chk("store_keeps_rdata", d_rdata, init_val(64'h20));
    idle(1); d_req = 0;
    idle(1); d_we = 0; d_req = 1;
    wait_ack(1, c); chk("load_back", d_rdata, 64'hCAFE_F00D_1234_5678);
    idle(1); d_req = 0;

    // Reset during the WAIT of a load
    idle(2); d_addr = 64'h30; d_we = 0; d_req = 1;
    idle(2); reset = 1; d_req = 0;
    idle(1); reset = 0;
    @(negedge clk); #2;
    chk("midrst_acks", {62'h0, d_ack, if_ack}, 64'h0);
    chk("midrst_strobes", {62'h0, mem_we, mem_re}, 64'h0);
    chk("midrst_mem_addr", mem_addr, 64'h0);
    chk("midrst_mem_wdata", mem_wdata, 64'h0);
    chk("midrst_if_rdata", {32'h0, if_rdata}, 64'h0);
    chk("midrst_d_rdata", d_rdata, 64'h0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); #2; seen |= d_ack; end
    chk("midrst_no_ack", 64'(seen), 64'h0);
    idle(1); d_req = 1; t = cyc;
    wait_ack(1, c);
    chk("rereq_latency", 64'(c - t), 64'(LAT + 2));
    chk("rereq_rdata", d_rdata, init_val(64'h30));
    idle(1); d_req = 0;
    idle(2);

    // Random traffic
    fork
      begin
        bit s;
        for (int k = 0; k < RCYC; k++) begin
          @(negedge clk); s = if_ack;
          @(posedge clk); #1;
          if (if_req && s) begin
            if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
            else if_req = 0;
          end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = rand_addr();
          end
        end
      end
      begin
        bit s;
        for (int k = 0; k < RCYC; k++) begin
          @(negedge clk); s = d_ack;
          @(posedge clk); #1;
          if ((d_req && s && $urandom_range(0, 1) == 1) || (!d_req && $urandom_range(0, 2) == 0)) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1));
            d_addr = rand_addr(); d_wdata = {$urandom, $urandom};
          end else if (d_req && s) d_req = 0;
        end
      end
    join
    for (int k = 0; k < 200 && (if_req || d_req); k++) begin
      @(negedge clk); si = if_ack; sd = d_ack;
      @(posedge clk); #1;
      if (si) if_req = 0;
      if (sd) d_req = 0;
    end
    chk("drain_done", {62'h0, if_req, d_req}, 64'h0);
    idle(6);
    chk("resp_queue_empty", 64'(rq.size()), 64'h0);
    chk("issue_queue_empty", 64'(iq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
